// File: rtl/fetch_queue.sv
// Circular instruction/PC queue between the fetch response path and decode.
// Define FETCH_QUEUE_BYPASS_EN to let an empty queue pass a fetch straight to decode in the same cycle.
module fetch_queue #(
    parameter int WORD_SIZE_P = 32'sd16,
    parameter int DEPTH_P     = 32'sd8
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         fetch_v_i,
    input  logic [WORD_SIZE_P-1:0]       fetch_instr_i,
    input  logic [WORD_SIZE_P-1:0]       fetch_pc_i,
    output logic                         fetch_ready_o,
    input  logic                         flush_i,
    output logic                         deq_v_o,
    output logic [WORD_SIZE_P-1:0]       deq_instr_o,
    output logic [WORD_SIZE_P-1:0]       deq_pc_o,
    input  logic                         deq_ready_i,
    output logic [$clog2(DEPTH_P):0]     count_o
);

    localparam int IDX_W   = $clog2(DEPTH_P);
    localparam int PTR_W   = IDX_W + 32'sd1;
    localparam int ENTRY_W = 32'sd2 * WORD_SIZE_P;

    logic [ENTRY_W-1:0] mem_r [DEPTH_P];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;

    logic               empty_s;
    logic               full_s;
    logic               bypass_s;
    logic               enq_s;
    logic               deq_s;
    logic               wr_en_s;
    logic               rd_adv_s;
    logic [ENTRY_W-1:0] head_s;

    // Occupancy flags: the extra MSB of each pointer separates full from empty.
    always_comb begin
        empty_s = (wr_ptr_r == rd_ptr_r);
        full_s  = (wr_ptr_r[IDX_W-1:0] == rd_ptr_r[IDX_W-1:0]) &&
                  (wr_ptr_r[IDX_W] != rd_ptr_r[IDX_W]);
    end

    // Same-cycle pass-through of a fetch into an empty queue.
    always_comb begin
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass_s = empty_s & fetch_v_i & ~flush_i & ~reset_i;
`else
        bypass_s = 1'b0;
`endif
    end

    // Handshakes; ready depends only on state, flush and reset, never on deq_ready_i.
    always_comb begin
        fetch_ready_o = ~full_s & ~flush_i & ~reset_i;
        deq_v_o       = (~empty_s | bypass_s) & ~flush_i & ~reset_i;
        enq_s         = fetch_v_i & fetch_ready_o;
        deq_s         = deq_v_o & deq_ready_i;
        // A bypassed entry consumed this cycle never touches storage.
        wr_en_s       = enq_s & ~(bypass_s & deq_ready_i);
        rd_adv_s      = deq_s & ~bypass_s;
    end

    // Head presentation, zeroed whenever nothing valid is shown.
    always_comb begin
        if (bypass_s) begin
            head_s = {fetch_instr_i, fetch_pc_i};
        end else begin
            head_s = mem_r[rd_ptr_r[IDX_W-1:0]];
        end
        if (deq_v_o) begin
            deq_instr_o = head_s[ENTRY_W-1:WORD_SIZE_P];
            deq_pc_o    = head_s[WORD_SIZE_P-1:0];
        end else begin
            deq_instr_o = '0;
            deq_pc_o    = '0;
        end
        count_o = wr_ptr_r - rd_ptr_r;
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r[IDX_W-1:0]] <= {fetch_instr_i, fetch_pc_i};
        end
    end

    // Pointer update; flush and reset both discard every entry.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else if (flush_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (rd_adv_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
        end
    end

endmodule
